// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage: request channel (valid/ready) plus
// an unhandshaked load-response channel carrying a full doubleword.
interface mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_write;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the in-order backend.
// Single-entry stage register with an IDLE/ALU/REQ/RESP FSM. Issues loads and
// stores on the dmem port, aligns/extends load data, bypasses the completing
// result to EX and registers it for writeback.
// Optional feature: define MEM_MISALIGN_CHECK_EN to complete misaligned
// loads/stores in the REQ cycle without a request and flag wb_misalign.
module mem_stage (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [63:0]       ex_pc,
  input  logic [31:0]       ex_instr,
  input  logic [4:0]        ex_rd,
  input  logic              ex_need_to_wb,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_is_unsigned,
  input  logic [3:0]        ex_ls_size,
  input  logic [63:0]       ex_ls_address,
  input  logic [63:0]       ex_store_data,
  input  logic [63:0]       ex_result,
  output logic              mem_stall,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic [63:0]       wb_pc,
  output logic [31:0]       wb_instr,
  output logic [4:0]        wb_rd,
  output logic              wb_need_to_wb,
  output logic [63:0]       wb_result,
  output logic              wb_misalign,
  output logic [4:0]        mem_byp_rd,
  output logic              mem_byp_need_to_wb,
  output logic [63:0]       mem_byp_result
);

  typedef enum logic [1:0] {S_IDLE, S_ALU, S_REQ, S_RESP} state_t;

  state_t      state, state_nxt;

  logic [63:0] e_pc;
  logic [31:0] e_instr;
  logic [4:0]  e_rd;
  logic        e_need;
  logic        e_load;
  logic        e_store;
  logic        e_unsigned;
  logic [3:0]  e_size;
  logic [63:0] e_addr;
  logic [63:0] e_sdata;
  logic [63:0] e_result;

  logic        misaligned;
  logic        done;
  logic        accept;
  logic        req_valid;
  logic [2:0]  offset;
  logic [5:0]  shamt;
  logic [7:0]  mask_base;
  logic [63:0] rd_shifted;
  logic [63:0] load_data;
  logic [63:0] result;
  logic        byp_need;

  // Stage register: captured on accept, cleared by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_pc       <= '0;
      e_instr    <= '0;
      e_rd       <= '0;
      e_need     <= 1'b0;
      e_load     <= 1'b0;
      e_store    <= 1'b0;
      e_unsigned <= 1'b0;
      e_size     <= '0;
      e_addr     <= '0;
      e_sdata    <= '0;
      e_result   <= '0;
    end else if (accept) begin
      e_pc       <= ex_pc;
      e_instr    <= ex_instr;
      e_rd       <= ex_rd;
      e_need     <= ex_need_to_wb;
      e_load     <= ex_is_load;
      e_store    <= ex_is_store;
      e_unsigned <= ex_is_unsigned;
      e_size     <= ex_ls_size;
      e_addr     <= ex_ls_address;
      e_sdata    <= ex_store_data;
      e_result   <= ex_result;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Misalignment is only meaningful while the access sits in REQ
  always_comb begin
    misaligned = 1'b0;
    if (state == S_REQ && (e_load || e_store)) begin
      if (e_size[3])      misaligned = |e_addr[2:0];
      else if (e_size[2]) misaligned = |e_addr[1:0];
      else if (e_size[1]) misaligned = e_addr[0];
    end
  end
`else
  // No alignment check in this build
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // Completion, accept and stall handshakes with EX
  always_comb begin
    done = (state == S_ALU)
         | ((state == S_REQ) && misaligned)
         | ((state == S_REQ) && e_store && dmem.req_ready && !misaligned)
         | ((state == S_RESP) && dmem.resp_valid);
    accept    = ex_valid && ((state == S_IDLE) || done);
    mem_stall = ex_valid && !((state == S_IDLE) || done);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = (ex_is_load || ex_is_store) ? S_REQ : S_ALU;
    else if (done)
      state_nxt = S_IDLE;
    else if (state == S_REQ && dmem.req_ready && e_load && !misaligned)
      state_nxt = S_RESP;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Request drive: zero outside REQ so the port is quiet when idle
  always_comb begin
    offset    = e_addr[2:0];
    shamt     = {offset, 3'b000};
    req_valid = (state == S_REQ) && !misaligned;
    if (e_size[0])      mask_base = 8'h01;
    else if (e_size[1]) mask_base = 8'h03;
    else if (e_size[2]) mask_base = 8'h0F;
    else if (e_size[3]) mask_base = 8'hFF;
    else                mask_base = 8'h00;
    dmem.req_valid = req_valid;
    dmem.req_write = req_valid && e_store;
    dmem.req_addr  = req_valid ? {e_addr[63:3], 3'b000} : '0;
    dmem.req_wdata = req_valid ? (e_sdata << shamt) : '0;
    dmem.req_wmask = req_valid ? (mask_base << offset) : '0;
  end

  // Load alignment and extension; bytes shifted in from above byte 7 are zero
  always_comb begin
    rd_shifted = dmem.resp_rdata >> shamt;
    if (e_size[0])
      load_data = {{56{!e_unsigned && rd_shifted[7]}}, rd_shifted[7:0]};
    else if (e_size[1])
      load_data = {{48{!e_unsigned && rd_shifted[15]}}, rd_shifted[15:0]};
    else if (e_size[2])
      load_data = {{32{!e_unsigned && rd_shifted[31]}}, rd_shifted[31:0]};
    else
      load_data = rd_shifted;
  end

  // Result selection and bypass back into EX
  always_comb begin
    if (misaligned)   result = '0;
    else if (e_load)  result = load_data;
    else if (e_store) result = '0;
    else              result = e_result;
    byp_need           = done && e_need && !e_store && !misaligned;
    mem_byp_rd         = e_rd;
    mem_byp_need_to_wb = byp_need;
    mem_byp_result     = result;
  end

  // Writeback registers: load on done, otherwise hold with wb_valid low
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_pc         <= '0;
      wb_instr      <= '0;
      wb_rd         <= '0;
      wb_need_to_wb <= 1'b0;
      wb_result     <= '0;
      wb_misalign   <= 1'b0;
    end else begin
      wb_valid <= done;
      if (done) begin
        wb_pc         <= e_pc;
        wb_instr      <= e_instr;
        wb_rd         <= e_rd;
        wb_need_to_wb <= byp_need;
        wb_result     <= result;
        wb_misalign   <= misaligned;
      end
    end
  end

endmodule
